apb_master_arbiter: RTL and testbench

- Shares one APB bus between NUM_REQ bus masters, for example the AHB-to-APB bridge and a DMA/debug master.
- Each master presents one transfer through a req/ack interface. The arbiter grants one master at a time (round-robin) and runs the APB SETUP/ACCESS sequence itself.
- Adds PREADY wait states, PSLVERR reporting and a PREADY timeout, none of which a plain bridge provides.
- Sits between the masters and the peripheral PSEL decoder. Its PSEL feeds the decoder in the same way psel_en does.

---
 rtl/apb_arb_pkg.sv | 17 +
 rtl/apb_master_arbiter_rr_pick.sv | 43 ++++
 rtl/apb_master_arbiter.sv | 176 +++++++++++++++++
 tb/tb_apb_master_arbiter.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_arb_pkg.sv
// Shared types and default widths for the APB master arbiter.
//   state_t     : arbiter FSM states (IDLE, SETUP, ACCESS)
//   Def*        : default parameter values used by apb_master_arbiter
package apb_arb_pkg;

   localparam int unsigned DefNumReq  = 2;
   localparam int unsigned DefAddrW   = 32;
   localparam int unsigned DefDataW   = 32;
   localparam int unsigned DefTimeout = 255;

   typedef enum logic [1:0] {
      IDLE,
      SETUP,
      ACCESS
   } state_t;

endpackage

// File: rtl/apb_master_arbiter_rr_pick.sv
// Combinational round-robin selector.
//   req  : request vector, one bit per master
//   last : index of the most recently granted master
//   gnt  : one-hot winner, the first set bit searching upward from last+1 with wrap
//   idx  : encoded index of the winner (0 when none)
//   any  : at least one request is set
module rr_pick #(
   parameter int unsigned NUM_REQ = 2
) (
   input  logic [NUM_REQ-1:0]         req,
   input  logic [$clog2(NUM_REQ)-1:0] last,
   output logic [NUM_REQ-1:0]         gnt,
   output logic [$clog2(NUM_REQ)-1:0] idx,
   output logic                       any
);

   localparam int unsigned IDX_W = $clog2(NUM_REQ);

   int unsigned       cand;
   logic [IDX_W-1:0]  cand_idx;

   always_comb begin
      gnt      = '0;
      idx      = '0;
      any      = 1'b0;
      cand     = 0;
      cand_idx = '0;
      // Offsets 1..NUM_REQ visit every master once, ending on last itself.
      for (int unsigned off = 1; off <= NUM_REQ; off++) begin
         cand = 32'(last) + off;
         if (cand >= NUM_REQ) begin
            cand = cand - NUM_REQ;
         end
         cand_idx = cand[IDX_W-1:0];
         if (!any && req[cand_idx]) begin
            any           = 1'b1;
            gnt[cand_idx] = 1'b1;
            idx           = cand_idx;
         end
      end
   end

endmodule

// File: rtl/apb_master_arbiter.sv
// Round-robin arbiter sharing one APB bus between NUM_REQ masters. It runs the
// SETUP/ACCESS sequence itself, handles PREADY wait states, reports PSLVERR and
// forces an error completion after TIMEOUT stalled ACCESS cycles (0 disables).
//   clk, n_rst         : clock, asynchronous active-low reset
//   req/req_write      : per-master level request and direction (1 = write)
//   req_addr/req_wdata : per-master payload, master i at [i*W +: W]
//   ack/rdata/err      : one-cycle one-hot completion with read data and error
//   grant              : one-hot owner during SETUP and ACCESS
//   PSEL..PWDATA       : APB master outputs (all registered)
//   PRDATA/PREADY/PSLVERR : APB slave responses
module apb_master_arbiter
   import apb_arb_pkg::*;
#(
   parameter int unsigned NUM_REQ = DefNumReq,
   parameter int unsigned ADDR_W  = DefAddrW,
   parameter int unsigned DATA_W  = DefDataW,
   parameter int unsigned TIMEOUT = DefTimeout
) (
   input  logic                       clk,
   input  logic                       n_rst,
   input  logic [NUM_REQ-1:0]         req,
   input  logic [NUM_REQ-1:0]         req_write,
   input  logic [NUM_REQ*ADDR_W-1:0]  req_addr,
   input  logic [NUM_REQ*DATA_W-1:0]  req_wdata,
   output logic [NUM_REQ-1:0]         ack,
   output logic [DATA_W-1:0]          rdata,
   output logic                       err,
   output logic [NUM_REQ-1:0]         grant,
   output logic                       PSEL,
   output logic                       PENABLE,
   output logic                       PWRITE,
   output logic [ADDR_W-1:0]          PADDR,
   output logic [DATA_W-1:0]          PWDATA,
   input  logic [DATA_W-1:0]          PRDATA,
   input  logic                       PREADY,
   input  logic                       PSLVERR
);

   localparam int unsigned      IDX_W    = $clog2(NUM_REQ);
   // Keep the counter at least one bit wide when the timeout is disabled.
   localparam int unsigned      CNT_W    = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'((TIMEOUT == 0) ? 32'd0 : TIMEOUT - 32'd1);
   localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(NUM_REQ - 1);

   state_t              state_q, state_d;
   logic [IDX_W-1:0]    last_q, last_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [NUM_REQ-1:0]  grant_q, grant_d;
   logic [NUM_REQ-1:0]  ack_q, ack_d;
   logic [DATA_W-1:0]   rdata_q, rdata_d;
   logic                err_q, err_d;
   logic                psel_q, psel_d;
   logic                penable_q, penable_d;
   logic                pwrite_q, pwrite_d;
   logic [ADDR_W-1:0]   paddr_q, paddr_d;
   logic [DATA_W-1:0]   pwdata_q, pwdata_d;

   logic [NUM_REQ-1:0]  eligible;
   logic [NUM_REQ-1:0]  pick_gnt;
   logic [IDX_W-1:0]    pick_idx;
   logic                pick_any;
   logic                timeout_hit;

   // The master being acked this cycle may still hold req; skip it once.
   assign eligible = req & ~ack_q;

   rr_pick #(
      .NUM_REQ (NUM_REQ)
   ) u_rr_pick (
      .req  (eligible),
      .last (last_q),
      .gnt  (pick_gnt),
      .idx  (pick_idx),
      .any  (pick_any)
   );

   assign timeout_hit = (TIMEOUT != 0) && (cnt_q == TMO_LAST);

   always_comb begin
      state_d   = state_q;
      last_d    = last_q;
      cnt_d     = cnt_q;
      grant_d   = grant_q;
      ack_d     = '0;
      rdata_d   = '0;
      err_d     = 1'b0;
      psel_d    = psel_q;
      penable_d = penable_q;
      pwrite_d  = pwrite_q;
      paddr_d   = paddr_q;
      pwdata_d  = pwdata_q;

      unique case (state_q)
         IDLE: begin
            psel_d    = 1'b0;
            penable_d = 1'b0;
            grant_d   = '0;
            if (pick_any) begin
               pwrite_d = req_write[pick_idx];
               paddr_d  = req_addr[32'(pick_idx) * ADDR_W +: ADDR_W];
               pwdata_d = req_wdata[32'(pick_idx) * DATA_W +: DATA_W];
               grant_d  = pick_gnt;
               last_d   = pick_idx;
               psel_d   = 1'b1;
               state_d  = SETUP;
            end
         end
         SETUP: begin
            psel_d    = 1'b1;
            penable_d = 1'b1;
            cnt_d     = '0;
            state_d   = ACCESS;
         end
         ACCESS: begin
            if (PREADY || timeout_hit) begin
               ack_d     = grant_q;
               err_d     = PREADY ? PSLVERR : 1'b1;
               rdata_d   = (PREADY && !pwrite_q) ? PRDATA : '0;
               grant_d   = '0;
               psel_d    = 1'b0;
               penable_d = 1'b0;
               state_d   = IDLE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: begin
            state_d   = IDLE;
            psel_d    = 1'b0;
            penable_d = 1'b0;
            grant_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_q   <= IDLE;
         last_q    <= LAST_RST;
         cnt_q     <= '0;
         grant_q   <= '0;
         ack_q     <= '0;
         rdata_q   <= '0;
         err_q     <= 1'b0;
         psel_q    <= 1'b0;
         penable_q <= 1'b0;
         pwrite_q  <= 1'b0;
         paddr_q   <= '0;
         pwdata_q  <= '0;
      end else begin
         state_q   <= state_d;
         last_q    <= last_d;
         cnt_q     <= cnt_d;
         grant_q   <= grant_d;
         ack_q     <= ack_d;
         rdata_q   <= rdata_d;
         err_q     <= err_d;
         psel_q    <= psel_d;
         penable_q <= penable_d;
         pwrite_q  <= pwrite_d;
         paddr_q   <= paddr_d;
         pwdata_q  <= pwdata_d;
      end
   end

   assign ack     = ack_q;
   assign rdata   = rdata_q;
   assign err     = err_q;
   assign grant   = grant_q;
   assign PSEL    = psel_q;
   assign PENABLE = penable_q;
   assign PWRITE  = pwrite_q;
   assign PADDR   = paddr_q;
   assign PWDATA  = pwdata_q;

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Directed bench for apb_master_arbiter (2 masters, TIMEOUT = 4): a cycle table
// for single reads, round-robin and mid-transfer req drop, followed by hand
// sequences for wait states + slave error, timeout, reset mid-ACCESS and payload
// changes after grant.
module tb_apb_master_arbiter;

   localparam int unsigned NR  = 2;
   localparam int unsigned AW  = 32;
   localparam int unsigned DW  = 32;
   localparam int unsigned TMO = 4;

   logic              clk = 1'b0;
   logic              n_rst = 1'b0;
   logic [NR-1:0]     req;
   logic [NR-1:0]     req_write;
   logic [AW-1:0]     addr_m [NR];
   logic [DW-1:0]     wdata_m [NR];
   logic [NR*AW-1:0]  req_addr;
   logic [NR*DW-1:0]  req_wdata;
   logic [NR-1:0]     ack;
   logic [DW-1:0]     rdata;
   logic              err;
   logic [NR-1:0]     grant;
   logic              PSEL, PENABLE, PWRITE;
   logic [AW-1:0]     PADDR;
   logic [DW-1:0]     PWDATA;
   logic [DW-1:0]     PRDATA;
   logic              PREADY, PSLVERR;

   assign req_addr  = {addr_m[1], addr_m[0]};
   assign req_wdata = {wdata_m[1], wdata_m[0]};

   apb_master_arbiter #(
      .NUM_REQ (NR),
      .ADDR_W  (AW),
      .DATA_W  (DW),
      .TIMEOUT (TMO)
   ) dut (
      .clk       (clk),
      .n_rst     (n_rst),
      .req       (req),
      .req_write (req_write),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .ack       (ack),
      .rdata     (rdata),
      .err       (err),
      .grant     (grant),
      .PSEL      (PSEL),
      .PENABLE   (PENABLE),
      .PWRITE    (PWRITE),
      .PADDR     (PADDR),
      .PWDATA    (PWDATA),
      .PRDATA    (PRDATA),
      .PREADY    (PREADY),
      .PSLVERR   (PSLVERR)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      logic [1:0]  rq;
      logic [31:0] prdata;
      logic        psel;
      logic        pen;
      logic [1:0]  grant;
      logic [1:0]  ack;
      logic [31:0] rdata;
   } vec_t;

   function automatic vec_t mk(input logic [1:0] rq, input logic [31:0] prd, input logic ps,
                               input logic pe, input logic [1:0] gr, input logic [1:0] ak,
                               input logic [31:0] rd);
      vec_t v;
      v.rq = rq; v.prdata = prd; v.psel = ps; v.pen = pe;
      v.grant = gr; v.ack = ak; v.rdata = rd;
      return v;
   endfunction

   localparam logic [31:0] D  = 32'hDEAD_BEEF;
   localparam logic [31:0] R  = 32'h1111_0000;
   localparam logic [31:0] R2 = 32'h2222_0000;

   vec_t tv [17];

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      int pen_cycles;
      logic [31:0] exp_addr;

      req = '0; req_write = '0; PREADY = 1'b1; PSLVERR = 1'b0; PRDATA = '0;
      addr_m[0] = 32'h8000_1004; addr_m[1] = 32'h8000_1008;
      wdata_m[0] = '0; wdata_m[1] = '0;

      // Reset state
      #3;
      chk("rst_psel", PSEL, 0);
      chk("rst_penable", PENABLE, 0);
      chk("rst_ack", ack, 0);
      chk("rst_grant", grant, 0);
      chk("rst_err", err, 0);
      chk("rst_rdata", rdata, 0);
      chk("rst_paddr", PADDR, 0);
      chk("rst_pwrite", PWRITE, 0);
      chk("rst_pwdata", PWDATA, 0);
      #19 n_rst = 1'b1;

      //           req    prdata psel pen grant  ack    rdata
      tv[0]  = mk(2'b01, D,  1, 0, 2'b01, 2'b00, 0);
      tv[1]  = mk(2'b01, D,  1, 1, 2'b01, 2'b00, 0);
      tv[2]  = mk(2'b01, D,  0, 0, 2'b00, 2'b01, D);
      tv[3]  = mk(2'b00, D,  0, 0, 2'b00, 2'b00, 0);
      tv[4]  = mk(2'b11, R,  1, 0, 2'b10, 2'b00, 0);
      tv[5]  = mk(2'b11, R,  1, 1, 2'b10, 2'b00, 0);
      tv[6]  = mk(2'b11, R,  0, 0, 2'b00, 2'b10, R);
      tv[7]  = mk(2'b11, R2, 1, 0, 2'b01, 2'b00, 0);
      tv[8]  = mk(2'b11, R2, 1, 1, 2'b01, 2'b00, 0);
      tv[9]  = mk(2'b11, R2, 0, 0, 2'b00, 2'b01, R2);
      tv[10] = mk(2'b11, R,  1, 0, 2'b10, 2'b00, 0);
      tv[11] = mk(2'b11, R,  1, 1, 2'b10, 2'b00, 0);
      tv[12] = mk(2'b11, R,  0, 0, 2'b00, 2'b10, R);
      tv[13] = mk(2'b11, R2, 1, 0, 2'b01, 2'b00, 0);
      // req drops mid-transfer: the transfer still completes
      tv[14] = mk(2'b00, R2, 1, 1, 2'b01, 2'b00, 0);
      tv[15] = mk(2'b00, R2, 0, 0, 2'b00, 2'b01, R2);
      tv[16] = mk(2'b00, R2, 0, 0, 2'b00, 2'b00, 0);

      for (int i = 0; i < 17; i++) begin
         req    = tv[i].rq;
         PRDATA = tv[i].prdata;
         tick();
         chk($sformatf("v%0d psel", i), PSEL, tv[i].psel);
         chk($sformatf("v%0d penable", i), PENABLE, tv[i].pen);
         chk($sformatf("v%0d grant", i), grant, tv[i].grant);
         chk($sformatf("v%0d ack", i), ack, tv[i].ack);
         chk($sformatf("v%0d pen_without_psel", i), PENABLE & ~PSEL, 0);
         if (tv[i].ack != 2'b00) begin
            chk($sformatf("v%0d rdata", i), rdata, tv[i].rdata);
            chk($sformatf("v%0d err", i), err, 0);
         end
         if (tv[i].psel) begin
            exp_addr = (tv[i].grant == 2'b01) ? 32'h8000_1004 : 32'h8000_1008;
            chk($sformatf("v%0d paddr", i), PADDR, exp_addr);
            chk($sformatf("v%0d pwrite", i), PWRITE, 0);
         end
      end

      // Wait states plus slave error: master 1 write, PREADY low for 3 ACCESS cycles
      req_write = 2'b10; addr_m[1] = 32'h8000_2000; wdata_m[1] = 32'h1234_5678;
      PREADY = 1'b0; PSLVERR = 1'b0; PRDATA = 32'hFFFF_0000; req = 2'b10;
      tick();
      chk("ws_psel", PSEL, 1);
      chk("ws_grant", grant, 2'b10);
      chk("ws_pwrite", PWRITE, 1);
      chk("ws_paddr", PADDR, 32'h8000_2000);
      tick();
      pen_cycles = 0;
      for (int i = 0; i < 4; i++) begin
         if (PENABLE) pen_cycles++;
         chk($sformatf("ws_pwdata_c%0d", i), PWDATA, 32'h1234_5678);
         if (i == 3) begin
            PREADY = 1'b1; PSLVERR = 1'b1;
         end
         tick();
      end
      chk("ws_pen_cycles", pen_cycles, 4);
      chk("ws_ack", ack, 2'b10);
      chk("ws_err", err, 1);
      chk("ws_rdata_write", rdata, 0);
      chk("ws_psel_drop", PSEL, 0);
      chk("ws_pen_drop", PENABLE, 0);
      req = '0; req_write = '0; PREADY = 1'b0; PSLVERR = 1'b0;
      tick();

      // Timeout: PREADY stuck low, master 0 read, master 1 waiting behind it
      PRDATA = 32'hAAAA_5555; req = 2'b11;
      tick();
      chk("to_grant", grant, 2'b01);
      tick();
      pen_cycles = 0;
      for (int i = 0; i < 20 && ack == 2'b00; i++) begin
         if (PENABLE) pen_cycles++;
         tick();
      end
      chk("to_access_cycles", pen_cycles, 4);
      chk("to_ack", ack, 2'b01);
      chk("to_err", err, 1);
      chk("to_rdata", rdata, 0);
      tick();
      chk("to_next_grant", grant, 2'b10);
      chk("to_next_psel", PSEL, 1);
      PREADY = 1'b1; req = 2'b00;
      tick();
      tick();
      chk("to_next_ack", ack, 2'b10);
      chk("to_next_err", err, 0);
      tick();

      // Reset mid-ACCESS: master 0 is last owner, so master 1 would be next without reset
      PREADY = 1'b0; req = 2'b01;
      tick();
      chk("rm_grant", grant, 2'b01);
      tick();
      chk("rm_penable", PENABLE, 1);
      #2 n_rst = 1'b0;
      #1;
      chk("rm_psel_async", PSEL, 0);
      chk("rm_pen_async", PENABLE, 0);
      chk("rm_grant_async", grant, 0);
      for (int i = 0; i < 2; i++) begin
         tick();
         chk($sformatf("rm_no_ack_%0d", i), ack, 0);
      end
      #2 n_rst = 1'b1;

      // Priority after reset, plus payload change after grant
      addr_m[0] = 32'h8000_3000; req = 2'b11; PREADY = 1'b1; PRDATA = 32'h5A5A_A5A5;
      tick();
      chk("rm_prio_grant", grant, 2'b01);
      chk("pl_paddr_setup", PADDR, 32'h8000_3000);
      addr_m[0] = 32'hFFFF_FFFF;
      req = 2'b01;
      tick();
      chk("pl_penable", PENABLE, 1);
      chk("pl_paddr_access", PADDR, 32'h8000_3000);
      req = 2'b00;
      tick();
      chk("pl_ack", ack, 2'b01);
      chk("pl_rdata", rdata, 32'h5A5A_A5A5);
      chk("pl_paddr_done", PADDR, 32'h8000_3000);
      tick();
      chk("pl_paddr_idle_hold", PADDR, 32'h8000_3000);
      chk("pl_idle_grant", grant, 0);
      chk("pl_idle_psel", PSEL, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
